kid_life_ctrl: RTL and testbench

Life-cycle sequencer for the kid sprite datapath: decides when the kid is alive, dying, waiting on the game-over screen, or being respawned. It drives the hold/reset and spawn coordinates into the kid's state updater and gates the kid's visibility into the pixel mux. It latches save points and keeps a saturating death counter for the HUD. It runs on the pixel-domain clock and advances only on a one-cycle frame tick (`update_tick`) produced by the existing clock divider.

---
 rtl/kid_pkg.sv | 21 ++
 rtl/kid_life_ctrl_timer.sv | 29 ++
 rtl/kid_life_ctrl.sv | 179 +++++++++++++++++
 tb/tb_kid_life_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/kid_pkg.sv
// Shared kid sprite definitions: life-cycle state encodings and sprite geometry.
// Also used by the sprite renderer and the collision logic.
package kid_pkg;

   typedef enum logic [1:0] {
      ALIVE    = 2'd0,
      DYING    = 2'd1,
      GAMEOVER = 2'd2,
      RESPAWN  = 2'd3
   } life_state_e;

   localparam int KID_W      = 31;
   localparam int KID_H      = 23;
   localparam int KID_HALF_W = 15;
   localparam int KID_HALF_H = 11;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/kid_life_ctrl_timer.sv
// Frame tick counter: synchronous clear, tick enable, compare against a limit.
// Counter saturates so a long stay in one state never fakes a match.
module frame_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_tick,
   input  logic       i_clr,
   input  logic [7:0] i_limit,
   output logic [7:0] o_count,
   output logic       o_done
);

   logic [7:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt <= 8'd0;
      end else if (i_tick) begin
         if (i_clr)
            r_cnt <= 8'd0;
         else if (r_cnt != 8'hFF)
            r_cnt <= r_cnt + 8'd1;
      end
   end

   assign o_count = r_cnt;
   assign o_done  = (r_cnt == i_limit);

endmodule

// File: rtl/kid_life_ctrl.sv
// Kid life-cycle sequencer: alive/dying/game-over/respawn, save points,
// saturating death counter. Everything advances on the frame tick only.
module kid_life_ctrl
   import kid_pkg::*;
#(
   parameter logic [9:0] INIT_X         = 10'd32,
   parameter logic [9:0] INIT_Y         = 10'd400,
   parameter int         DIE_FRAMES     = 60,
   parameter int         BLINK_FRAMES   = 4,
   parameter int         RESPAWN_FRAMES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       update_tick,
   input  logic [9:0] kid_x,
   input  logic [9:0] kid_y,
   input  logic       hazard_hit,
   input  logic       save_hit,
   input  logic       restart_key,
   output logic       kid_rst,
   output logic [9:0] spawn_x,
   output logic [9:0] spawn_y,
   output logic       kid_visible,
   output logic       gameover_show,
   output logic [7:0] death_cnt,
   output logic [1:0] life_state
);

   localparam logic [7:0] DIE_LIM   = 8'(DIE_FRAMES - 1);
   localparam logic [7:0] BLINK_LIM = 8'(BLINK_FRAMES - 1);
   localparam logic [7:0] RSP_LIM   = 8'(RESPAWN_FRAMES - 1);

   life_state_e r_state;
   life_state_e w_nxt;

   logic       r_rst_prev;
   logic [9:0] r_spawn_x;
   logic [9:0] r_spawn_y;
   logic [7:0] r_deaths;
   logic [7:0] r_blink_cnt;
   logic       r_blink;
   logic       r_kid_rst;
   logic       r_vis;
   logic       r_go;

   logic       w_edge;
   logic       w_done;
   logic       w_clr;
   logic [7:0] w_limit;
   logic [7:0] w_count;
   logic       w_save;
   logic       w_death;
   logic [7:0] w_blink_cnt_nxt;
   logic       w_blink_nxt;
   logic       w_kid_rst_nxt;
   logic       w_vis_nxt;
   logic       w_go_nxt;

   assign w_edge  = restart_key & ~r_rst_prev;
   assign w_limit = (r_state == DYING) ? DIE_LIM : RSP_LIM;
   assign w_clr   = (w_nxt != r_state);

   frame_timer u_timer (
      .clk     (clk),
      .rst     (rst),
      .i_tick  (update_tick),
      .i_clr   (w_clr),
      .i_limit (w_limit),
      .o_count (w_count),
      .o_done  (w_done)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst)
         r_state <= RESPAWN;
      else if (update_tick)
         r_state <= w_nxt;
   end

   // Next-state logic
   always_comb begin
      w_nxt = r_state;
      unique case (r_state)
         ALIVE: begin
            if (hazard_hit)
               w_nxt = DYING;
            else if (w_edge)
               w_nxt = RESPAWN;
         end
         DYING: begin
            if (w_done)
               w_nxt = GAMEOVER;
         end
         GAMEOVER: begin
            if (w_edge)
               w_nxt = RESPAWN;
         end
         RESPAWN: begin
            if (w_done)
               w_nxt = ALIVE;
         end
         default: w_nxt = RESPAWN;
      endcase
   end

   // Blink phase restarts dark on every entry into DYING
   always_comb begin
      w_blink_cnt_nxt = r_blink_cnt;
      w_blink_nxt     = r_blink;
      if (w_nxt == DYING && r_state != DYING) begin
         w_blink_cnt_nxt = 8'd0;
         w_blink_nxt     = 1'b0;
      end else if (r_state == DYING) begin
         if (r_blink_cnt == BLINK_LIM) begin
            w_blink_cnt_nxt = 8'd0;
            w_blink_nxt     = ~r_blink;
         end else begin
            w_blink_cnt_nxt = r_blink_cnt + 8'd1;
         end
      end
   end

   // Output decode of the upcoming state
   always_comb begin
      w_kid_rst_nxt = 1'b0;
      w_vis_nxt     = 1'b0;
      w_go_nxt      = 1'b0;
      unique case (w_nxt)
         ALIVE:    w_vis_nxt     = 1'b1;
         DYING:    w_vis_nxt     = w_blink_nxt;
         GAMEOVER: w_go_nxt      = 1'b1;
         RESPAWN:  w_kid_rst_nxt = 1'b1;
         default:  w_kid_rst_nxt = 1'b1;
      endcase
   end

   assign w_save  = (r_state == ALIVE) & ~hazard_hit & ~w_edge & save_hit;
   assign w_death = (r_state == ALIVE) & hazard_hit;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rst_prev  <= 1'b1;
         r_spawn_x   <= INIT_X;
         r_spawn_y   <= INIT_Y;
         r_deaths    <= 8'd0;
         r_blink_cnt <= 8'd0;
         r_blink     <= 1'b0;
         r_kid_rst   <= 1'b1;
         r_vis       <= 1'b0;
         r_go        <= 1'b0;
      end else if (update_tick) begin
         r_rst_prev  <= restart_key;
         r_blink_cnt <= w_blink_cnt_nxt;
         r_blink     <= w_blink_nxt;
         r_kid_rst   <= w_kid_rst_nxt;
         r_vis       <= w_vis_nxt;
         r_go        <= w_go_nxt;
         if (w_save) begin
            r_spawn_x <= kid_x - 10'(KID_HALF_W);
            r_spawn_y <= kid_y - 10'(KID_HALF_H);
         end
         if (w_death)
            r_deaths <= sat_inc8(r_deaths);
      end
   end

   assign kid_rst       = r_kid_rst;
   assign kid_visible   = r_vis;
   assign gameover_show = r_go;
   assign spawn_x       = r_spawn_x;
   assign spawn_y       = r_spawn_y;
   assign death_cnt     = r_deaths;
   assign life_state    = r_state;

   logic w_unused;
   assign w_unused = ^w_count;

endmodule

// File: tb/tb_kid_life_ctrl.sv
// Directed bench for kid_life_ctrl.
// Hand-computed expectations checked with immediate assertions.
module tb_kid_life_ctrl;

   logic       clk;
   logic       rst;
   logic       update_tick;
   logic [9:0] kid_x;
   logic [9:0] kid_y;
   logic       hazard_hit;
   logic       save_hit;
   logic       restart_key;
   logic       kid_rst;
   logic [9:0] spawn_x;
   logic [9:0] spawn_y;
   logic       kid_visible;
   logic       gameover_show;
   logic [7:0] death_cnt;
   logic [1:0] life_state;

   int checks;
   int failures;

   kid_life_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .update_tick   (update_tick),
      .kid_x         (kid_x),
      .kid_y         (kid_y),
      .hazard_hit    (hazard_hit),
      .save_hit      (save_hit),
      .restart_key   (restart_key),
      .kid_rst       (kid_rst),
      .spawn_x       (spawn_x),
      .spawn_y       (spawn_y),
      .kid_visible   (kid_visible),
      .gameover_show (gameover_show),
      .death_cnt     (death_cnt),
      .life_state    (life_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      update_tick = 1'b1;
      @(posedge clk);
      #1;
      update_tick = 1'b0;
   endtask

   task automatic idle_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_d;
      checks      = 0;
      failures    = 0;
      rst         = 1'b0;
      update_tick = 1'b0;
      kid_x       = 10'd0;
      kid_y       = 10'd0;
      hazard_hit  = 1'b0;
      save_hit    = 1'b0;
      restart_key = 1'b0;

      // Reset state
      idle_clk(2);
      chk("rst_state", 32'(life_state), 32'd3);
      chk("rst_kid_rst", 32'(kid_rst), 32'd1);
      chk("rst_vis", 32'(kid_visible), 32'd0);
      chk("rst_go", 32'(gameover_show), 32'd0);
      chk("rst_sx", 32'(spawn_x), 32'd32);
      chk("rst_sy", 32'(spawn_y), 32'd400);
      chk("rst_deaths", 32'(death_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Respawn after two ticks
      tick();
      chk("rsp1_kid_rst", 32'(kid_rst), 32'd1);
      chk("rsp1_state", 32'(life_state), 32'd3);
      idle_clk(3);
      chk("hold_state", 32'(life_state), 32'd3);
      tick();
      chk("rsp2_kid_rst", 32'(kid_rst), 32'd0);
      chk("rsp2_vis", 32'(kid_visible), 32'd1);
      chk("rsp2_state", 32'(life_state), 32'd0);

      // Save point, then a wrapping save, then restore
      kid_x = 10'd100; kid_y = 10'd200; save_hit = 1'b1;
      idle_clk(2);
      chk("save_no_tick", 32'(spawn_x), 32'd32);
      tick();
      chk("save_sx", 32'(spawn_x), 32'd85);
      chk("save_sy", 32'(spawn_y), 32'd189);
      kid_x = 10'd5; kid_y = 10'd3;
      tick();
      chk("wrap_sx", 32'(spawn_x), 32'd1014);
      chk("wrap_sy", 32'(spawn_y), 32'd1016);
      kid_x = 10'd100; kid_y = 10'd200;
      tick();
      chk("restore_sx", 32'(spawn_x), 32'd85);

      // Hazard wins over save
      kid_x = 10'd300; kid_y = 10'd300; hazard_hit = 1'b1;
      tick();
      hazard_hit = 1'b0; save_hit = 1'b0;
      chk("hz_state", 32'(life_state), 32'd1);
      chk("hz_sx", 32'(spawn_x), 32'd85);
      chk("hz_sy", 32'(spawn_y), 32'd189);
      chk("hz_deaths", 32'(death_cnt), 32'd1);
      chk("hz_vis", 32'(kid_visible), 32'd0);

      // Blink pattern; save/hazard ignored while dying
      for (int k = 1; k <= 59; k++) begin
         if (k == 20) begin
            hazard_hit = 1'b1; save_hit = 1'b1;
         end
         if (k == 21) begin
            hazard_hit = 1'b0; save_hit = 1'b0;
         end
         if (k == 50) restart_key = 1'b1;
         tick();
         chk($sformatf("blink_%0d", k), 32'(kid_visible), 32'((k / 4) % 2));
         chk($sformatf("dying_%0d", k), 32'(life_state), 32'd1);
      end
      chk("dying_deaths", 32'(death_cnt), 32'd1);
      chk("dying_sx", 32'(spawn_x), 32'd85);
      tick();
      chk("go_state", 32'(life_state), 32'd2);
      chk("go_show", 32'(gameover_show), 32'd1);
      chk("go_vis", 32'(kid_visible), 32'd0);

      // Key held through entry must not restart
      repeat (3) tick();
      chk("go_held", 32'(life_state), 32'd2);
      restart_key = 1'b0;
      tick();
      chk("go_release", 32'(life_state), 32'd2);
      restart_key = 1'b1;
      tick();
      chk("go_press_state", 32'(life_state), 32'd3);
      chk("go_press_rst", 32'(kid_rst), 32'd1);
      chk("go_press_show", 32'(gameover_show), 32'd0);
      tick();
      chk("rsp_a_rst", 32'(kid_rst), 32'd1);
      tick();
      chk("rsp_b_state", 32'(life_state), 32'd0);
      chk("rsp_b_rst", 32'(kid_rst), 32'd0);
      chk("rsp_b_vis", 32'(kid_visible), 32'd1);
      chk("rsp_b_sx", 32'(spawn_x), 32'd85);
      chk("rsp_b_sy", 32'(spawn_y), 32'd189);

      // Restart from ALIVE: no death counted
      restart_key = 1'b0;
      tick();
      chk("alive_rel", 32'(life_state), 32'd0);
      restart_key = 1'b1;
      tick();
      chk("alive_restart", 32'(life_state), 32'd3);
      chk("alive_restart_d", 32'(death_cnt), 32'd1);
      restart_key = 1'b0;
      tick();
      tick();
      chk("alive_back", 32'(life_state), 32'd0);

      // Drive deaths up to and past saturation
      for (int i = 2; i <= 256; i++) begin
         exp_d = (i > 255) ? 255 : i;
         hazard_hit = 1'b1;
         tick();
         hazard_hit = 1'b0;
         chk($sformatf("sat_d_%0d", i), 32'(death_cnt), 32'(exp_d));
         repeat (60) tick();
         chk($sformatf("sat_go_%0d", i), 32'(life_state), 32'd2);
         restart_key = 1'b1;
         tick();
         restart_key = 1'b0;
         tick();
         tick();
         chk($sformatf("sat_alive_%0d", i), 32'(life_state), 32'd0);
      end
      chk("sat_final", 32'(death_cnt), 32'd255);

      // Reset mid-DYING
      hazard_hit = 1'b1;
      tick();
      hazard_hit = 1'b0;
      repeat (5) tick();
      chk("pre_rst_state", 32'(life_state), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_state", 32'(life_state), 32'd3);
      chk("mid_rst_sx", 32'(spawn_x), 32'd32);
      chk("mid_rst_sy", 32'(spawn_y), 32'd400);
      chk("mid_rst_d", 32'(death_cnt), 32'd0);
      chk("mid_rst_kr", 32'(kid_rst), 32'd1);
      chk("mid_rst_vis", 32'(kid_visible), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
